// File: rtl/rotate_sched.sv
// rtl/rotate_sched.sv - round-robin shared rotate engine, up to 3 positions per pass
module rotate_sched #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_dir,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_dir,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic [WIDTH-1:0] req1_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy
);
    localparam int LW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LW-1:0]    rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;

    logic             grant0, grant1;
    logic [LW-1:0]    step;
    logic [2*WIDTH-1:0] dbl, dbl_sh;
    logic [WIDTH-1:0] rot;
    logic             unused_amt;

    // Only the low log2(WIDTH) amount bits matter: rotation is modulo WIDTH.
    assign unused_amt = ^{req0_amt, req1_amt};

    assign grant0     = req0_valid & (~req1_valid | last_grant_q);
    assign grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;

    assign resp_valid = (state_q == RESP);
    assign resp_data  = data_q;
    assign resp_id    = id_q;
    assign busy       = (state_q != IDLE);

    // One rotator pass: take the matching half of the doubled word.
    always_comb begin
        step   = (rem_q > LW'(3)) ? LW'(3) : rem_q;
        dbl    = {data_q, data_q};
        dbl_sh = '0;
        rot    = '0;
        if (dir_q) begin
            dbl_sh = dbl << step;
            rot    = dbl_sh[2*WIDTH-1:WIDTH];
        end else begin
            dbl_sh = dbl >> step;
            rot    = dbl_sh[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        rem_d        = rem_q;
        dir_d        = dir_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    id_d         = grant1;
                    last_grant_d = grant1;
                    data_d       = grant1 ? req1_data : req0_data;
                    dir_d        = grant1 ? req1_dir : req0_dir;
                    rem_d        = grant1 ? req1_amt[LW-1:0] : req0_amt[LW-1:0];
                    state_d      = (rem_d == '0) ? RESP : SHIFT;
                end
            end
            SHIFT: begin
                data_d = rot;
                rem_d  = rem_q - step;
                if (rem_d == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            data_q       <= '0;
            rem_q        <= '0;
            dir_q        <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            rem_q        <= rem_d;
            dir_q        <= dir_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end
endmodule
